// File: rtl/traffic_pkg.sv
// Shared types for the N-phase traffic sequencer: FSM state enum, mode codes,
// and the saturating duration-edit helper used by the set modes.
// No ports; imported by traffic_phase_seq and phase_timer.
package traffic_pkg;

    typedef enum logic [2:0] {
        STOP   = 3'd0,
        NIGHT  = 3'd1,
        GREEN  = 3'd2,
        YELLOW = 3'd3,
        ALLRED = 3'd4
    } state_t;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_SET_G = 2'b10;
    localparam logic [1:0] MODE_SET_Y = 2'b11;

    // One key step on a duration: +1 up to max_v, -1 down to 1.
    // Both keys together (or neither) leave the value unchanged.
    function automatic logic [31:0] sat_step(input logic [31:0] val,
                                             input logic        inc,
                                             input logic        dec,
                                             input logic [31:0] max_v);
        logic [31:0] r;
        r = val;
        if (inc && !dec)
            r = (val >= max_v) ? max_v : val + 32'd1;
        else if (dec && !inc)
            r = (val <= 32'd1) ? 32'd1 : val - 32'd1;
        return r;
    endfunction

endpackage

// File: rtl/traffic_phase_seq_timer.sv
// phase_timer: loadable down-counter timing one lamp interval.
// Ports: clk/rst, load+load_val (priority), tick, hold (freeze) -> cnt, expire.
// cnt decrements on tick while >1; expire = tick & cnt==1 so an interval of N lasts N ticks.
module phase_timer
    import traffic_pkg::*;
#(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt,
    output logic             expire
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (tick && !hold && (cnt > CNT_W'(1)))
            cnt <= cnt - CNT_W'(1);
    end

    assign expire = tick && (cnt == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_seq.sv
// traffic_phase_seq: N-phase sequencer with per-phase green/yellow, night flash,
// in-field duration editing, peak-hour green doubling and priority phase jump.
// Ports: clk, rst, tick, mode, sel_phase, key_inc/dec, peak, req_valid/phase -> req_ready,
//        lamp_r/y/g, cur_phase, cnt_remain, set_val. Optional macro: TRAFFIC_ALLRED_EN.
module traffic_phase_seq
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 11,
    parameter int GREEN_DEF  = 30,
    parameter int YELLOW_DEF = 5,
    parameter int DUR_MAX    = 999,
    parameter int PEAK_PHASE = 0,
    localparam int PW        = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [1:0]            mode,
    input  logic [PW-1:0]         sel_phase,
    input  logic                  key_inc,
    input  logic                  key_dec,
    input  logic                  peak,
    input  logic                  req_valid,
    input  logic [PW-1:0]         req_phase,
    output logic                  req_ready,
    output logic [NUM_PHASES-1:0] lamp_r,
    output logic [NUM_PHASES-1:0] lamp_y,
    output logic [NUM_PHASES-1:0] lamp_g,
    output logic [PW-1:0]         cur_phase,
    output logic [CNT_W-1:0]      cnt_remain,
    output logic [CNT_W-1:0]      set_val
);

    localparam logic [PW:0] NP = (PW+1)'(NUM_PHASES);

    state_t              state_q, state_d;
    logic [PW-1:0]       phase_q, phase_d, target_q, target_d, nxt_phase;
    logic                pend_q, pend_d, blink_q, blink_d;
    logic [CNT_W-1:0]    green_q  [NUM_PHASES];
    logic [CNT_W-1:0]    yellow_q [NUM_PHASES];
    logic                load, expire, accept, tick_run, sel_ok;
    logic [CNT_W-1:0]    load_val, cnt, eff_green0, eff_green_nxt;
    logic [NUM_PHASES-1:0] onehot;

    // Peak doubling saturates at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] eff_green(input logic [CNT_W-1:0] g,
                                                   input logic [PW-1:0]    p,
                                                   input logic             pk);
        logic [CNT_W:0] dbl;
        dbl = {g, 1'b0};
        if (pk && ({1'b0, p} == (PW+1)'(PEAK_PHASE)))
            return dbl[CNT_W] ? '1 : dbl[CNT_W-1:0];
        return g;
    endfunction

    assign sel_ok    = ({1'b0, sel_phase} < NP);
    assign req_ready = (state_q == GREEN) && (mode == MODE_RUN) &&
                       (req_phase != phase_q) && ({1'b0, req_phase} < NP);
    assign accept    = req_valid && req_ready;
    // An accepted jump reloads the counter, so a coincident tick is dropped.
    assign tick_run  = tick && (mode == MODE_RUN) && !accept;

    assign nxt_phase     = pend_q ? target_q :
                           ({1'b0, phase_q} == NP - (PW+1)'(1)) ? '0 : phase_q + PW'(1);
    assign eff_green0    = eff_green(green_q[0], '0, peak);
    assign eff_green_nxt = eff_green(green_q[nxt_phase], nxt_phase, peak);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tick     (tick_run),
        .hold     (mode[1]),
        .cnt      (cnt),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STOP;
            phase_q  <= '0;
            target_q <= '0;
            pend_q   <= 1'b0;
            blink_q  <= 1'b0;
            for (int i = 0; i < NUM_PHASES; i++) begin
                green_q[i]  <= CNT_W'(GREEN_DEF);
                yellow_q[i] <= CNT_W'(YELLOW_DEF);
            end
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            target_q <= target_d;
            pend_q   <= pend_d;
            blink_q  <= blink_d;
            if (mode == MODE_SET_G && sel_ok)
                green_q[sel_phase] <= CNT_W'(sat_step(32'(green_q[sel_phase]),
                                                      key_inc, key_dec, 32'(DUR_MAX)));
            if (mode == MODE_SET_Y && sel_ok)
                yellow_q[sel_phase] <= CNT_W'(sat_step(32'(yellow_q[sel_phase]),
                                                       key_inc, key_dec, 32'(DUR_MAX)));
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        target_d = target_q;
        pend_d   = pend_q;
        blink_d  = blink_q;
        load     = 1'b0;
        load_val = '0;
        case (mode)
            MODE_NIGHT: begin
                state_d = NIGHT;
                load    = 1'b1;
                if (state_q == NIGHT && tick)
                    blink_d = ~blink_q;
            end
            MODE_RUN: begin
                case (state_q)
                    STOP, NIGHT: begin
                        state_d  = GREEN;
                        phase_d  = '0;
                        pend_d   = 1'b0;
                        load     = 1'b1;
                        load_val = eff_green0;
                    end
                    GREEN: begin
                        if (accept || expire) begin
                            state_d  = YELLOW;
                            load     = 1'b1;
                            load_val = yellow_q[phase_q];
                        end
                        if (accept) begin
                            pend_d   = 1'b1;
                            target_d = req_phase;
                        end
                    end
                    YELLOW: begin
                        if (expire) begin
`ifdef TRAFFIC_ALLRED_EN
                            state_d  = ALLRED;
                            load     = 1'b1;
                            load_val = CNT_W'(1);
`else
                            state_d  = GREEN;
                            phase_d  = nxt_phase;
                            pend_d   = 1'b0;
                            load     = 1'b1;
                            load_val = eff_green_nxt;
`endif
                        end
                    end
`ifdef TRAFFIC_ALLRED_EN
                    ALLRED: begin
                        if (expire) begin
                            state_d  = GREEN;
                            phase_d  = nxt_phase;
                            pend_d   = 1'b0;
                            load     = 1'b1;
                            load_val = eff_green_nxt;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            default: ;  // set modes: sequence frozen
        endcase
    end

    always_comb begin
        onehot          = '0;
        onehot[phase_q] = 1'b1;
        lamp_r = '1;
        lamp_y = '0;
        lamp_g = '0;
        case (state_q)
            NIGHT: begin
                lamp_r = '0;
                lamp_y = {NUM_PHASES{blink_q}};
            end
            GREEN: begin
                lamp_r = ~onehot;
                lamp_g = onehot;
            end
            YELLOW: begin
                lamp_r = ~onehot;
                lamp_y = onehot;
            end
            default: ;
        endcase
    end

    always_comb begin
        set_val = cnt;
        if (mode == MODE_SET_G)
            set_val = sel_ok ? green_q[sel_phase] : '0;
        else if (mode == MODE_SET_Y)
            set_val = sel_ok ? yellow_q[sel_phase] : '0;
    end

    assign cur_phase  = phase_q;
    assign cnt_remain = cnt;

endmodule

// File: tb/tb_traffic_phase_seq.sv
module tb_traffic_phase_seq;

`ifdef TRAFFIC_ALLRED_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif
    localparam int PER = 30 + 5 + AR;

    logic        clk = 1'b0;
    logic        rst, tick, key_inc, key_dec, peak, req_valid, req_ready;
    logic [1:0]  mode, sel_phase, req_phase, cur_phase;
    logic [3:0]  lamp_r, lamp_y, lamp_g;
    logic [10:0] cnt_remain, set_val;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    traffic_phase_seq dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .mode       (mode),
        .sel_phase  (sel_phase),
        .key_inc    (key_inc),
        .key_dec    (key_dec),
        .peak       (peak),
        .req_valid  (req_valid),
        .req_phase  (req_phase),
        .req_ready  (req_ready),
        .lamp_r     (lamp_r),
        .lamp_y     (lamp_y),
        .lamp_g     (lamp_g),
        .cur_phase  (cur_phase),
        .cnt_remain (cnt_remain),
        .set_val    (set_val)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout n_assert=%0d", n_assert);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic push(input int v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input int obs);
        int e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=<empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; mode = 2'b00; sel_phase = 2'd0;
        key_inc = 1'b0; key_dec = 1'b0; peak = 1'b0;
        req_valid = 1'b0; req_phase = 2'd0;
        push(15); push(0); push(0); push(0); push(0); push(0);
        step(); step();
        chk("rst_lamp_r", int'(lamp_r));
        chk("rst_lamp_y", int'(lamp_y));
        chk("rst_lamp_g", int'(lamp_g));
        chk("rst_cnt", int'(cnt_remain));
        chk("rst_phase", int'(cur_phase));
        chk("rst_req_ready", int'(req_ready));

        // Leave reset in run mode: STOP -> GREEN(0), 30 loaded.
        rst = 1'b0;
        push(30); push(1); push(14);
        step();
        chk("g0_load_cnt", int'(cnt_remain));
        chk("g0_lamp_g", int'(lamp_g));
        chk("g0_lamp_r", int'(lamp_r));

        push(1); push(1);
        run_ticks(29);
        chk("g0_last_cnt", int'(cnt_remain));
        chk("g0_still_green", int'(lamp_g));

        push(5); push(1); push(14);
        run_ticks(1);
        chk("y0_cnt", int'(cnt_remain));
        chk("y0_lamp_y", int'(lamp_y));
        chk("y0_lamp_r", int'(lamp_r));

`ifdef TRAFFIC_ALLRED_EN
        push(15);
        run_ticks(5);
        chk("allred_lamp_r", int'(lamp_r));
        run_ticks(1);
`else
        run_ticks(5);
`endif
        push(1); push(30); push(2);
        chk("g1_phase", int'(cur_phase));
        chk("g1_cnt", int'(cnt_remain));
        chk("g1_lamp_g", int'(lamp_g));

        push(0); push(30);
        run_ticks(3 * PER);
        chk("wrap_phase", int'(cur_phase));
        chk("wrap_cnt", int'(cnt_remain));

        // Edit green of phase 2 while frozen.
        mode = 2'b10; sel_phase = 2'd2;
        step();
        key_inc = 1'b1;
        repeat (3) step();
        key_inc = 1'b0;
        push(33); push(30); push(1);
        chk("set_g2_val", int'(set_val));
        run_ticks(1);
        chk("set_freeze_cnt", int'(cnt_remain));
        chk("set_freeze_lamp", int'(lamp_g));

        mode = 2'b00;
        push(1); push(30);
        run_ticks(PER);
        chk("g1b_phase", int'(cur_phase));
        chk("g1b_cnt", int'(cnt_remain));
        push(2); push(33);
        run_ticks(PER);
        chk("g2_phase", int'(cur_phase));
        chk("g2_cnt_edited", int'(cnt_remain));
        push(3); push(30);
        run_ticks(33 + 5 + AR);
        chk("g3_phase", int'(cur_phase));
        chk("g3_cnt", int'(cnt_remain));
        push(0); push(30);
        run_ticks(PER);
        chk("g0b_phase", int'(cur_phase));
        chk("g0b_cnt", int'(cnt_remain));

        // Priority jump to phase 3 from phase 0 green at cnt 20.
        push(20);
        run_ticks(10);
        chk("jump_pre_cnt", int'(cnt_remain));
        req_valid = 1'b1; req_phase = 2'd3;
        #1;
        push(1);
        chk("jump_ready", int'(req_ready));
        push(0); push(1); push(5);
        run_ticks(1);  // accept and tick together: tick dropped
        chk("jump_y_phase", int'(cur_phase));
        chk("jump_y_lamp", int'(lamp_y));
        chk("jump_y_cnt", int'(cnt_remain));
        #1;
        push(0);
        chk("jump_ready_in_yellow", int'(req_ready));
        req_valid = 1'b0;
        push(3); push(30); push(8);
        run_ticks(5 + AR);
        chk("jump_target_phase", int'(cur_phase));
        chk("jump_target_cnt", int'(cnt_remain));
        chk("jump_target_lamp", int'(lamp_g));
        #1;
        push(0);
        chk("ready_same_phase", int'(req_ready));

        // Peak doubling on phase 0 load, then sampled only at load.
        peak = 1'b1;
        push(0); push(60);
        run_ticks(PER);
        chk("peak_phase", int'(cur_phase));
        chk("peak_cnt", int'(cnt_remain));
        peak = 1'b0;
        push(59);
        run_ticks(1);
        chk("peak_hold_cnt", int'(cnt_remain));

        // Night flash.
        mode = 2'b01;
        push(0); push(0); push(0); push(0);
        step();
        chk("night_lamp_g", int'(lamp_g));
        chk("night_lamp_r", int'(lamp_r));
        chk("night_lamp_y0", int'(lamp_y));
        chk("night_cnt", int'(cnt_remain));
        push(15);
        run_ticks(1);
        chk("night_lamp_y1", int'(lamp_y));
        push(0);
        run_ticks(1);
        chk("night_lamp_y2", int'(lamp_y));
        mode = 2'b00;
        push(0); push(30); push(1);
        step();
        chk("night_exit_phase", int'(cur_phase));
        chk("night_exit_cnt", int'(cnt_remain));
        chk("night_exit_lamp", int'(lamp_g));

        // Saturation of edits on phase 1.
        mode = 2'b11; sel_phase = 2'd1;
        step();
        key_dec = 1'b1;
        repeat (10) step();
        key_dec = 1'b0;
        push(1);
        chk("yellow_sat_min", int'(set_val));
        mode = 2'b10;
        key_inc = 1'b1;
        repeat (1000) step();
        push(999);
        chk("green_sat_max", int'(set_val));
        key_dec = 1'b1;
        step();
        push(999);
        chk("inc_dec_same_cycle", int'(set_val));
        key_inc = 1'b0;
        step();
        key_dec = 1'b0;
        push(998);
        chk("dec_from_max", int'(set_val));
        sel_phase = 2'd2;
        #1;
        push(33);
        chk("other_phase_green", int'(set_val));

        // Reset mid-operation restores defaults and STOP.
        rst = 1'b1;
        step();
        rst = 1'b0;
        push(30); push(15); push(0);
        chk("rst_mid_green_def", int'(set_val));
        chk("rst_mid_lamp_r", int'(lamp_r));
        chk("rst_mid_cnt", int'(cnt_remain));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
